// File: rtl/pattern_gen_pkg.sv
// Shared types and constants for the Avalon-ST test pattern generator:
// pattern modes, FSM states, the RGB pixel struct and the colour-bar palette.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    BARS  = 2'd0,
    GRAD  = 2'd1,
    CHECK = 2'd2,
    SOLID = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EOF  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COLOR_WHITE   = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t COLOR_YELLOW  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
  localparam rgb_t COLOR_CYAN    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
  localparam rgb_t COLOR_GREEN   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam rgb_t COLOR_MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
  localparam rgb_t COLOR_RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam rgb_t COLOR_BLUE    = '{r: 8'h00, g: 8'h00, b: 8'hFF};
  localparam rgb_t COLOR_BLACK   = '{r: 8'h00, g: 8'h00, b: 8'h00};

  // Left-to-right colour bar palette, indexed by the 3-bit bar counter.
  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = COLOR_WHITE;
      3'd1:    c = COLOR_YELLOW;
      3'd2:    c = COLOR_CYAN;
      3'd3:    c = COLOR_GREEN;
      3'd4:    c = COLOR_MAGENTA;
      3'd5:    c = COLOR_RED;
      3'd6:    c = COLOR_BLUE;
      default: c = COLOR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pattern_gen_color.sv
// Purely combinational pixel colour lookup: maps the latched pattern mode,
// raster position, bar index and frame counter to a 24-bit RGB value.
module pattern_gen_color
  import pattern_gen_pkg::*;
#(
  parameter int CHECK_LOG2 = 5
) (
  input  mode_t       mode,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [2:0]  bar,
  input  logic [15:0] frame_cnt,
  output rgb_t        pixel
);

  // Only a few position/counter bits feed the patterns; the rest are
  // folded here so the full-width interface stays tidy.
  logic unused_bits;
  assign unused_bits = ^{x[10:8], y, frame_cnt[15:8]};

  // Select the pattern colour for the given position.
  always_comb begin
    pixel = COLOR_BLACK;
    case (mode)
      BARS:    pixel = bar_color(bar);
      GRAD:    pixel = '{r: x[7:0], g: x[7:0], b: x[7:0]};
      CHECK:   pixel = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? COLOR_WHITE : COLOR_BLACK;
      SOLID:   pixel = '{r: frame_cnt[7:0], g: 8'h00, b: ~frame_cnt[7:0]};
      default: pixel = COLOR_BLACK;
    endcase
  end

endmodule

// File: rtl/avalon_st_pattern_gen.sv
// Avalon-ST raster test pattern source (colour bars, gradient, checkerboard,
// frame-animated solid). Owns the raster counters, frame FSM and the fully
// registered output stage; colours come from pattern_gen_color.
// Optional macro PATTERN_GEN_SOP_EOP_EN adds st_out_sop/st_out_eop frame markers.
module avalon_st_pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic [23:0] st_out_data,
  output logic        st_out_valid,
  input  logic        st_out_ready,
  output logic [15:0] frame_cnt,
  output logic        busy
`ifdef PATTERN_GEN_SOP_EOP_EN
  ,
  output logic        st_out_sop,
  output logic        st_out_eop
`endif
);

  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE - 1);
  localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);

  state_t      state_reg, state_next;
  mode_t       mode_reg, mode_next;
  logic [10:0] x_reg, x_next;
  logic [10:0] y_reg, y_next;
  logic [10:0] bar_px_reg, bar_px_next;
  logic [2:0]  bar_reg, bar_next;
  logic [15:0] frame_reg, frame_next;
  logic [23:0] data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        busy_reg, busy_next;
  logic        load;
  logic        accept;
  rgb_t        pixel;

  assign accept = valid_reg & st_out_ready;

  // The colour is looked up from the *next* counter values so the output
  // register can be loaded with the following pixel in the same cycle.
  pattern_gen_color #(
    .CHECK_LOG2(CHECK_LOG2)
  ) u_color (
    .mode      (mode_next),
    .x         (x_next),
    .y         (y_next),
    .bar       (bar_next),
    .frame_cnt (frame_next),
    .pixel     (pixel)
  );

  // Next-state logic: frame FSM, raster/bar counters and handshake control.
  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    bar_px_next = bar_px_reg;
    bar_next    = bar_reg;
    frame_next  = frame_reg;
    valid_next  = valid_reg;
    busy_next   = busy_reg;
    load        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          mode_next   = mode_t'(mode);
          x_next      = '0;
          y_next      = '0;
          bar_px_next = '0;
          bar_next    = '0;
          valid_next  = 1'b1;
          busy_next   = 1'b1;
          load        = 1'b1;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (x_reg == H_LAST) begin
            x_next      = '0;
            bar_px_next = '0;
            bar_next    = '0;
            if (y_reg == V_LAST) begin
              // Last pixel gone: drop valid for the single EOF cycle.
              y_next     = '0;
              frame_next = frame_reg + 16'd1;
              valid_next = 1'b0;
              state_next = EOF;
            end else begin
              y_next = y_reg + 11'd1;
              load   = 1'b1;
            end
          end else begin
            x_next = x_reg + 11'd1;
            load   = 1'b1;
            if (bar_px_reg == BAR_LAST) begin
              bar_px_next = '0;
              bar_next    = bar_reg + 3'd1;
            end else begin
              bar_px_next = bar_px_reg + 11'd1;
            end
          end
        end
      end
      EOF: begin
        if (enable) begin
          mode_next   = mode_t'(mode);
          x_next      = '0;
          y_next      = '0;
          bar_px_next = '0;
          bar_next    = '0;
          valid_next  = 1'b1;
          load        = 1'b1;
          state_next  = RUN;
        end else begin
          valid_next = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output data only changes when a new pixel is loaded, which gives the hold rule.
  always_comb begin
    data_next = load ? pixel : data_reg;
  end

`ifdef PATTERN_GEN_SOP_EOP_EN
  logic sop_reg, sop_next;
  logic eop_reg, eop_next;

  // Frame markers travel with the data and are held the same way.
  always_comb begin
    sop_next = sop_reg;
    eop_next = eop_reg;
    if (load) begin
      sop_next = (x_next == 11'd0) && (y_next == 11'd0);
      eop_next = (x_next == H_LAST) && (y_next == V_LAST);
    end
  end

  // Register the frame markers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sop_reg <= 1'b0;
      eop_reg <= 1'b0;
    end else begin
      sop_reg <= sop_next;
      eop_reg <= eop_next;
    end
  end

  assign st_out_sop = sop_reg;
  assign st_out_eop = eop_reg;
`endif

  // State register: FSM, counters and the registered output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      mode_reg   <= BARS;
      x_reg      <= '0;
      y_reg      <= '0;
      bar_px_reg <= '0;
      bar_reg    <= '0;
      frame_reg  <= '0;
      data_reg   <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      bar_px_reg <= bar_px_next;
      bar_reg    <= bar_next;
      frame_reg  <= frame_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
      busy_reg   <= busy_next;
    end
  end

  assign st_out_data  = data_reg;
  assign st_out_valid = valid_reg;
  assign frame_cnt    = frame_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_avalon_st_pattern_gen.sv
// Self-checking bench for avalon_st_pattern_gen on a reduced 320x8 raster.
// Captures every accepted beat, then compares against a table of hand-computed
// probe pixels and an independent full-frame reference model.
module tb_avalon_st_pattern_gen;

  localparam int H     = 320;
  localparam int V     = 8;
  localparam int CL    = 2;
  localparam int FRAME = H * V;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        st_out_ready = 1'b0;
  logic [23:0] st_out_data;
  logic        st_out_valid;
  logic [15:0] frame_cnt;
  logic        busy;
  logic [1:0]  flags;

`ifdef PATTERN_GEN_SOP_EOP_EN
  logic st_out_sop, st_out_eop;
  assign flags = {st_out_sop, st_out_eop};
`else
  assign flags = 2'b00;
`endif

  always #5 clk = ~clk;

  avalon_st_pattern_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .CHECK_LOG2(CL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .st_out_data(st_out_data), .st_out_valid(st_out_valid),
    .st_out_ready(st_out_ready), .frame_cnt(frame_cnt), .busy(busy)
`ifdef PATTERN_GEN_SOP_EOP_EN
    , .st_out_sop(st_out_sop), .st_out_eop(st_out_eop)
`endif
  );

  typedef struct {
    int          slot;
    int          x;
    int          y;
    logic [23:0] exp;
  } probe_t;

  int          tests = 0;
  int          fails = 0;
  logic [23:0] cap  [6][FRAME];
  logic [1:0]  capf [6][FRAME];
  logic [23:0] bar_tab [8];
  probe_t      probes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  function automatic logic [23:0] model(input int md, input int x, input int y, input int fc);
    logic [7:0] f;
    logic [7:0] g;
    f = fc[7:0];
    g = x[7:0];
    case (md)
      0:       return bar_tab[x / (H / 8)];
      1:       return {g, g, g};
      2:       return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return {f, 8'h00, ~f};
    endcase
  endfunction

  // Runs from the current negedge until nb beats are accepted. Optionally
  // toggles ready, changes mode after beat sw_beat, drops enable after drop_beat.
  task automatic collect(input int slot, input int nb, input bit toggle,
                         input int sw_beat, input logic [1:0] sw_mode, input int drop_beat);
    int          beats = 0;
    int          cyc = 0;
    int          hold_err = 0;
    bit          stall = 1'b0;
    logic [25:0] prev = '0;
    while (beats < nb && cyc < 4 * FRAME) begin
      if (stall && (!st_out_valid || {flags, st_out_data} !== prev)) hold_err++;
      st_out_ready = toggle ? ~st_out_ready : 1'b1;
      if (st_out_valid && st_out_ready) begin
        cap[slot][beats]  = st_out_data;
        capf[slot][beats] = flags;
        beats++;
        if (beats == sw_beat) mode = sw_mode;
        if (beats == drop_beat) enable = 1'b0;
      end
      stall = st_out_valid && !st_out_ready;
      prev  = {flags, st_out_data};
      @(negedge clk);
      cyc++;
    end
    check($sformatf("slot%0d beats", slot), beats, nb);
    check($sformatf("slot%0d hold", slot), hold_err, 0);
  endtask

  // Called at the negedge right after the last beat was accepted.
  task automatic eof_check(input int fc, input bit restart, input logic [23:0] first_px);
    check("eof valid", {31'd0, st_out_valid}, 0);
    check("eof frame_cnt", {16'd0, frame_cnt}, fc);
    check("eof busy", {31'd0, busy}, 1);
    @(negedge clk);
    if (restart) begin
      check("restart valid", {31'd0, st_out_valid}, 1);
      check("restart pixel", {8'd0, st_out_data}, first_px);
    end else begin
      check("post-eof valid", {31'd0, st_out_valid}, 0);
      check("post-eof busy", {31'd0, busy}, 0);
    end
  endtask

  task automatic score(input int slot, input int md, input int fc);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (cap[slot][i] !== model(md, i % H, i / H, fc)) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    check($sformatf("slot%0d pixels (first bad idx %0d)", slot, first), bad, 0);
`ifdef PATTERN_GEN_SOP_EOP_EN
    begin
      int nsop = 0, neop = 0, sop_at = -1, eop_at = -1;
      for (int i = 0; i < FRAME; i++) begin
        if (capf[slot][i][1]) begin nsop++; sop_at = i; end
        if (capf[slot][i][0]) begin neop++; eop_at = i; end
      end
      check($sformatf("slot%0d sop count", slot), nsop, 1);
      check($sformatf("slot%0d sop index", slot), sop_at, 0);
      check($sformatf("slot%0d eop count", slot), neop, 1);
      check($sformatf("slot%0d eop index", slot), eop_at, FRAME - 1);
    end
`endif
  endtask

  initial begin
    bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Hand-computed probes: {slot, x, y, expected}. Bars are 40 px wide here.
    probes.push_back('{0,   0, 0, 24'hFFFFFF});
    probes.push_back('{0,  39, 0, 24'hFFFFFF});
    probes.push_back('{0,  40, 0, 24'hFFFF00});
    probes.push_back('{0,  80, 1, 24'h00FFFF});
    probes.push_back('{0, 120, 2, 24'h00FF00});
    probes.push_back('{0, 160, 3, 24'hFF00FF});
    probes.push_back('{0, 200, 4, 24'hFF0000});
    probes.push_back('{0, 100, 5, 24'h00FFFF});
    probes.push_back('{0, 101, 5, 24'h00FFFF});
    probes.push_back('{0, 240, 6, 24'h0000FF});
    probes.push_back('{0, 279, 7, 24'h0000FF});
    probes.push_back('{0, 280, 7, 24'h000000});
    probes.push_back('{1,   0, 0, 24'h0100FE});
    probes.push_back('{1, 319, 7, 24'h0100FE});
    probes.push_back('{2, 300, 0, 24'h2C2C2C});
    probes.push_back('{2, 255, 3, 24'hFFFFFF});
    probes.push_back('{2, 256, 3, 24'h000000});
    probes.push_back('{2,  17, 7, 24'h111111});
    probes.push_back('{3,   0, 0, 24'h000000});
    probes.push_back('{3,   4, 0, 24'hFFFFFF});
    probes.push_back('{3,   4, 4, 24'h000000});
    probes.push_back('{3,   0, 4, 24'hFFFFFF});
    probes.push_back('{3,   3, 3, 24'h000000});
    probes.push_back('{3, 319, 7, 24'h000000});
    probes.push_back('{4,   0, 0, 24'hFFFFFF});
    probes.push_back('{4, 319, 0, 24'h000000});

    reset_n = 1'b0; enable = 1'b1; mode = 2'd0; st_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset valid", {31'd0, st_out_valid}, 0);
    check("reset data", {8'd0, st_out_data}, 0);
    check("reset frame_cnt", {16'd0, frame_cnt}, 0);
    check("reset busy", {31'd0, busy}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("first valid", {31'd0, st_out_valid}, 1);
    check("first busy", {31'd0, busy}, 1);
    check("first pixel", {8'd0, st_out_data}, 24'hFFFFFF);

    // Frame A: bars; mode switches to solid after pixel (100,5).
    collect(0, FRAME, 1'b0, 5 * H + 101, 2'd3, 0);
    eof_check(1, 1'b1, 24'h0100FE);
    // Frame B: solid with ready toggling; next frame gradient.
    collect(1, FRAME, 1'b1, 10, 2'd1, 0);
    eof_check(2, 1'b1, 24'h000000);
    // Frame C: gradient with ready toggling; next frame checkerboard.
    collect(2, FRAME, 1'b1, 10, 2'd2, 0);
    eof_check(3, 1'b1, 24'h000000);
    // Frame D: checkerboard, enable dropped mid-frame.
    collect(3, FRAME, 1'b0, 10, 2'd0, FRAME / 2);
    eof_check(4, 1'b0, 24'h0);
    repeat (3) @(negedge clk);
    check("idle valid", {31'd0, st_out_valid}, 0);
    check("idle busy", {31'd0, busy}, 0);
    enable = 1'b1;
    @(negedge clk);
    check("idle start valid", {31'd0, st_out_valid}, 1);
    check("idle start pixel", {8'd0, st_out_data}, 24'hFFFFFF);

    // Partial frame, then reset mid-line.
    collect(5, 50, 1'b0, 0, 2'd0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("async reset valid", {31'd0, st_out_valid}, 0);
    check("async reset busy", {31'd0, busy}, 0);
    check("async reset frame_cnt", {16'd0, frame_cnt}, 0);
    check("async reset data", {8'd0, st_out_data}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post-reset valid", {31'd0, st_out_valid}, 1);
    check("post-reset pixel", {8'd0, st_out_data}, 24'hFFFFFF);
    collect(4, FRAME, 1'b1, 0, 2'd0, 0);
    eof_check(1, 1'b1, 24'hFFFFFF);

    score(0, 0, 0);
    score(1, 3, 1);
    score(2, 1, 2);
    score(3, 2, 3);
    score(4, 0, 0);

    for (int i = 0; i < probes.size(); i++) begin
      check($sformatf("probe slot%0d (%0d,%0d)", probes[i].slot, probes[i].x, probes[i].y),
            {8'd0, cap[probes[i].slot][probes[i].y * H + probes[i].x]}, {8'd0, probes[i].exp});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
